// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the N-issue hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  localparam int NREG_AW = 5;
  typedef logic [NREG_AW-1:0] reg_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXC  = 1'b1
  } flush_state_e;

  localparam int DEF_ISSUE_W   = 2;
  localparam int DEF_LOAD_LAT  = 2;
  localparam int DEF_FLUSH_CYC = 2;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/hazard_sb_if.sv
// Pipeline-control bundle between the decode/stall sources and hazard_sb.
// Latency: n/a (wires only).
// Backpressure: stall inputs flow in, stage enables/flushes flow out.
// Ports: master drives decode lanes and stall/flush causes; slave (hazard_sb)
// returns stage enables, stage flushes, per-lane issue mask and stall count.
interface hazard_sb_if
  import hazard_pkg::*;
#(
  parameter int ISSUE_W = DEF_ISSUE_W,
  parameter int CNT_W   = DEF_CNT_W
);
  logic                      i_stall, d_stall, E_alu_stall;
  logic [ISSUE_W-1:0]        D_valid, D_we, D_is_load;
  reg_addr_t [ISSUE_W-1:0]   D_rs, D_rt, D_waddr;
  logic                      E_branch_taken, M_except;
  logic                      F_ena, D_ena, E_ena, M_ena, W_ena;
  logic                      F_flush, D_flush, E_flush, M_flush, W_flush;
  logic [ISSUE_W-1:0]        D_issue_mask;
  logic [CNT_W-1:0]          lu_stall_cnt;

  modport master (
    output i_stall, d_stall, E_alu_stall, D_valid, D_we, D_is_load,
           D_rs, D_rt, D_waddr, E_branch_taken, M_except,
    input  F_ena, D_ena, E_ena, M_ena, W_ena,
           F_flush, D_flush, E_flush, M_flush, W_flush,
           D_issue_mask, lu_stall_cnt
  );

  modport slave (
    input  i_stall, d_stall, E_alu_stall, D_valid, D_we, D_is_load,
           D_rs, D_rt, D_waddr, E_branch_taken, M_except,
    output F_ena, D_ena, E_ena, M_ena, W_ena,
           F_flush, D_flush, E_flush, M_flush, W_flush,
           D_issue_mask, lu_stall_cnt
  );
endinterface

// File: rtl/hazard_ld_shadow.sv
// Load-shadow shift array: remembers in-flight load destinations per lane and
// flags any source address that hits one. Latency: match is combinational on
// the registered array. Backpressure: hold_i freezes the array.
// Ports: clk/resetn; hold_i, clear_i (drop all), kill_i (drop newest row);
// ld_v_i/ld_dst_i new loads; src_i per-lane source; match_o per-lane hit.
module hazard_ld_shadow
  import hazard_pkg::*;
#(
  parameter int ISSUE_W  = DEF_ISSUE_W,
  parameter int LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    hold_i,
  input  logic                    clear_i,
  input  logic                    kill_i,
  input  logic [ISSUE_W-1:0]      ld_v_i,
  input  reg_addr_t [ISSUE_W-1:0] ld_dst_i,
  input  reg_addr_t [ISSUE_W-1:0] src_i,
  output logic [ISSUE_W-1:0]      match_o
);
  // Row 0 is the load now in E, row LOAD_LAT-1 the oldest still unforwardable.
  logic [LOAD_LAT-1:0][ISSUE_W-1:0]      sb_v_q, sb_v_d;
  reg_addr_t [LOAD_LAT-1:0][ISSUE_W-1:0] sb_dst_q, sb_dst_d;

  always_comb begin
    sb_v_d   = sb_v_q;
    sb_dst_d = sb_dst_q;
    if (!hold_i) begin
      for (int k = LOAD_LAT - 1; k > 0; k--) begin
        sb_v_d[k]   = sb_v_q[k-1];
        sb_dst_d[k] = sb_dst_q[k-1];
      end
      sb_v_d[0]   = kill_i ? '0 : ld_v_i;
      sb_dst_d[0] = ld_dst_i;
    end
    // An exception squashes every younger load, even while the pipe is frozen.
    if (clear_i) sb_v_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_v_q   <= '0;
      sb_dst_q <= '0;
    end else begin
      sb_v_q   <= sb_v_d;
      sb_dst_q <= sb_dst_d;
    end
  end

  always_comb begin
    match_o = '0;
    for (int l = 0; l < ISSUE_W; l++)
      for (int k = 0; k < LOAD_LAT; k++)
        for (int m = 0; m < ISSUE_W; m++)
          if (src_i[l] != '0 && sb_v_q[k][m] && sb_dst_q[k][m] == src_i[l])
            match_o[l] = 1'b1;
  end
endmodule

// File: rtl/hazard_sb.sv
// N-issue hazard unit: load-use scoreboard, intra-bundle RAW, prefix issue,
// exception flush sequencer and saturating load-use stall counter.
// Latency: all controls combinational from inputs and registered state.
// Backpressure: long stalls freeze everything; load-use/RAW stall F/D only.
// Ports: clk, resetn (async, active low), hz_if (slave side of hazard_sb_if).
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int ISSUE_W   = DEF_ISSUE_W,
  parameter int LOAD_LAT  = DEF_LOAD_LAT,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  hazard_sb_if.slave hz_if
);
  localparam int                FCNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC - 1);

  logic               ls, lwstall, e_flush, d_flush, d_ena, prev_ok;
  logic [ISSUE_W-1:0] rs_hit, rt_hit, hz, issue, ld_v;
  flush_state_e       state_q, state_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]   lu_q, lu_d;

  assign ls      = hz_if.i_stall | hz_if.d_stall | hz_if.E_alu_stall;
  assign e_flush = hz_if.M_except | hz_if.E_branch_taken;
  assign d_flush = e_flush | (state_q == EXC);

  // Only issued loads that really write a nonzero GPR enter the shadow.
  always_comb begin
    ld_v = '0;
    for (int l = 0; l < ISSUE_W; l++)
      ld_v[l] = issue[l] & hz_if.D_valid[l] & hz_if.D_is_load[l] &
                hz_if.D_we[l] & (hz_if.D_waddr[l] != '0);
  end

  hazard_ld_shadow #(.ISSUE_W(ISSUE_W), .LOAD_LAT(LOAD_LAT)) u_sb_rs (
    .clk(clk), .resetn(resetn), .hold_i(ls), .clear_i(hz_if.M_except),
    .kill_i(e_flush), .ld_v_i(ld_v), .ld_dst_i(hz_if.D_waddr),
    .src_i(hz_if.D_rs), .match_o(rs_hit)
  );

  hazard_ld_shadow #(.ISSUE_W(ISSUE_W), .LOAD_LAT(LOAD_LAT)) u_sb_rt (
    .clk(clk), .resetn(resetn), .hold_i(ls), .clear_i(hz_if.M_except),
    .kill_i(e_flush), .ld_v_i(ld_v), .ld_dst_i(hz_if.D_waddr),
    .src_i(hz_if.D_rt), .match_o(rt_hit)
  );

  // A lane is blocked by a shadowed load, or by any older lane in the same
  // bundle writing one of its sources ($0 never counts).
  always_comb begin
    hz = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      hz[l] = hz_if.D_valid[l] & (rs_hit[l] | rt_hit[l]);
      for (int m = 0; m < l; m++)
        if (hz_if.D_we[m] && hz_if.D_waddr[m] != '0 &&
            (hz_if.D_waddr[m] == hz_if.D_rs[l] || hz_if.D_waddr[m] == hz_if.D_rt[l]))
          hz[l] = hz_if.D_valid[l];
    end
  end

  // In-order prefix issue: the first blocked lane stops every younger lane.
  always_comb begin
    issue   = '0;
    prev_ok = ~ls & ~d_flush;
    for (int l = 0; l < ISSUE_W; l++) begin
      issue[l] = prev_ok & hz_if.D_valid[l] & ~hz[l];
      prev_ok  = issue[l];
    end
  end

  assign lwstall = hz_if.D_valid[0] & hz[0];
  assign d_ena   = ~(ls | lwstall);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz_if.M_except) begin
      state_d = EXC;
      cnt_d   = FCNT_LOAD;
    end else if (state_q == EXC) begin
      if (cnt_q == '0)  state_d = IDLE;
      else if (!ls)     cnt_d   = cnt_q - FCNT_W'(1);
    end
  end

  always_comb begin
    lu_d = lu_q;
    if (lwstall && !ls && !d_flush && lu_q != '1) lu_d = lu_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lu_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lu_q    <= lu_d;
    end
  end

  assign hz_if.D_ena        = d_ena;
  assign hz_if.F_ena        = d_ena & (issue == hz_if.D_valid);
  assign hz_if.E_ena        = ~ls;
  assign hz_if.M_ena        = ~ls;
  // Writeback still retires the excepting instruction past an ALU stall.
  assign hz_if.W_ena        = ~ls | (hz_if.E_alu_stall & hz_if.M_except);
  assign hz_if.F_flush      = (state_q == EXC);
  assign hz_if.D_flush      = d_flush;
  assign hz_if.E_flush      = e_flush;
  assign hz_if.M_flush      = hz_if.M_except;
  assign hz_if.W_flush      = 1'b0;
  assign hz_if.D_issue_mask = issue;
  assign hz_if.lu_stall_cnt = lu_q;
endmodule

// File: tb/tb_hazard_sb.sv
// Directed self-checking bench for hazard_sb (ISSUE_W=2, LOAD_LAT=2,
// FLUSH_CYC=2, CNT_W=3 so counter saturation is reachable).
module tb_hazard_sb;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_sb_if #(.ISSUE_W(2), .CNT_W(3)) hif ();

  hazard_sb #(.ISSUE_W(2), .LOAD_LAT(2), .FLUSH_CYC(2), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .hz_if(hif.slave)
  );

  task automatic clear_in();
    hif.i_stall = 0; hif.d_stall = 0; hif.E_alu_stall = 0;
    hif.D_valid = '0; hif.D_we = '0; hif.D_is_load = '0;
    hif.D_rs = '0; hif.D_rt = '0; hif.D_waddr = '0;
    hif.E_branch_taken = 0; hif.M_except = 0;
  endtask

  task automatic set_lane(input int l, input logic ld, input logic we,
                          input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt);
    hif.D_valid[l] = 1'b1; hif.D_is_load[l] = ld; hif.D_we[l] = we;
    hif.D_waddr[l] = wa; hif.D_rs[l] = rs; hif.D_rt[l] = rt;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle(input int n);
    clear_in();
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_in();
    set_lane(0, 0, 1, 5'd4, 5'd1, 5'd2);
    set_lane(1, 0, 1, 5'd6, 5'd3, 5'd5);
    repeat (2) cyc();
    settle();
    checks++; if ({hif.F_ena, hif.D_ena, hif.E_ena, hif.M_ena, hif.W_ena} !== 5'b11111) begin failures++; $display("FAIL reset_enables got=%b exp=11111", {hif.F_ena, hif.D_ena, hif.E_ena, hif.M_ena, hif.W_ena}); end
    checks++; if ({hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.W_flush} !== 5'b00000) begin failures++; $display("FAIL reset_flushes got=%b exp=00000", {hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.W_flush}); end
    checks++; if (hif.D_issue_mask !== 2'b11) begin failures++; $display("FAIL reset_mask got=%b exp=11", hif.D_issue_mask); end
    checks++; if (hif.lu_stall_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", hif.lu_stall_cnt); end
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_load_use();
    idle(3);
    set_lane(0, 1, 1, 5'd5, 5'd1, 5'd2);
    settle();
    checks++; if (hif.D_issue_mask !== 2'b01) begin failures++; $display("FAIL lu_load_mask got=%b exp=01", hif.D_issue_mask); end
    for (int i = 0; i < 2; i++) begin
      cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd5, 5'd0); settle();
      checks++; if ({hif.D_ena, hif.F_ena} !== 2'b00) begin failures++; $display("FAIL lu_stall%0d D/F_ena got=%b exp=00", i, {hif.D_ena, hif.F_ena}); end
    end
    cyc(); settle();
    checks++; if ({hif.D_ena, hif.F_ena, hif.D_issue_mask} !== 4'b1101) begin failures++; $display("FAIL lu_issue D/F_ena,mask got=%b exp=1101", {hif.D_ena, hif.F_ena, hif.D_issue_mask}); end
    checks++; if (hif.lu_stall_cnt !== 3'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", hif.lu_stall_cnt); end
  endtask

  task automatic test_lane1_shadow();
    idle(3);
    set_lane(0, 0, 1, 5'd10, 5'd1, 5'd2);
    set_lane(1, 1, 1, 5'd7, 5'd3, 5'd4);
    settle();
    checks++; if (hif.D_issue_mask !== 2'b11) begin failures++; $display("FAIL l1_load_mask got=%b exp=11", hif.D_issue_mask); end
    cyc(); clear_in();
    set_lane(0, 0, 0, 5'd0, 5'd8, 5'd9);
    set_lane(1, 0, 0, 5'd0, 5'd7, 5'd0);
    settle();
    checks++; if ({hif.D_issue_mask, hif.F_ena, hif.D_ena} !== 4'b0101) begin failures++; $display("FAIL l1_partial mask,F,D got=%b exp=0101", {hif.D_issue_mask, hif.F_ena, hif.D_ena}); end
    cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd7, 5'd0); settle();
    checks++; if ({hif.D_issue_mask, hif.D_ena} !== 3'b000) begin failures++; $display("FAIL l1_shift_stall mask,D got=%b exp=000", {hif.D_issue_mask, hif.D_ena}); end
    cyc(); settle();
    checks++; if ({hif.D_issue_mask, hif.F_ena} !== 3'b011) begin failures++; $display("FAIL l1_clear mask,F got=%b exp=011", {hif.D_issue_mask, hif.F_ena}); end
    checks++; if (hif.lu_stall_cnt !== 3'd3) begin failures++; $display("FAIL l1_cnt got=%0d exp=3", hif.lu_stall_cnt); end
  endtask

  task automatic test_intra_raw();
    idle(3);
    set_lane(0, 0, 1, 5'd3, 5'd1, 5'd2);
    set_lane(1, 0, 0, 5'd0, 5'd3, 5'd0);
    settle();
    checks++; if ({hif.D_issue_mask, hif.F_ena, hif.D_ena} !== 4'b0101) begin failures++; $display("FAIL raw_rs mask,F,D got=%b exp=0101", {hif.D_issue_mask, hif.F_ena, hif.D_ena}); end
    cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd3, 5'd0); settle();
    checks++; if ({hif.D_issue_mask, hif.F_ena} !== 3'b011) begin failures++; $display("FAIL raw_repres mask,F got=%b exp=011", {hif.D_issue_mask, hif.F_ena}); end
    cyc(); clear_in();
    set_lane(0, 0, 1, 5'd6, 5'd1, 5'd2);
    set_lane(1, 0, 0, 5'd0, 5'd0, 5'd6);
    settle();
    checks++; if (hif.D_issue_mask !== 2'b01) begin failures++; $display("FAIL raw_rt mask got=%b exp=01", hif.D_issue_mask); end
  endtask

  task automatic test_zero();
    idle(3);
    set_lane(0, 1, 1, 5'd0, 5'd0, 5'd0);
    set_lane(1, 0, 0, 5'd0, 5'd0, 5'd0);
    settle();
    checks++; if (hif.D_issue_mask !== 2'b11) begin failures++; $display("FAIL zero_bundle mask got=%b exp=11", hif.D_issue_mask); end
    cyc(); clear_in();
    set_lane(0, 0, 0, 5'd0, 5'd0, 5'd0);
    set_lane(1, 0, 0, 5'd0, 5'd0, 5'd0);
    settle();
    checks++; if ({hif.D_issue_mask, hif.D_ena} !== 3'b111) begin failures++; $display("FAIL zero_use mask,D got=%b exp=111", {hif.D_issue_mask, hif.D_ena}); end
    checks++; if (hif.lu_stall_cnt !== 3'd3) begin failures++; $display("FAIL zero_cnt got=%0d exp=3", hif.lu_stall_cnt); end
  endtask

  task automatic test_except();
    idle(3);
    set_lane(0, 1, 1, 5'd9, 5'd1, 5'd2);
    cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd9, 5'd0); hif.M_except = 1; settle();
    checks++; if ({hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.W_flush} !== 5'b01110) begin failures++; $display("FAIL exc_c0 flushes got=%b exp=01110", {hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.W_flush}); end
    checks++; if ({hif.D_issue_mask, hif.D_ena} !== 3'b000) begin failures++; $display("FAIL exc_c0 mask,D got=%b exp=000", {hif.D_issue_mask, hif.D_ena}); end
    cyc(); hif.M_except = 0; settle();
    checks++; if ({hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush} !== 4'b1100) begin failures++; $display("FAIL exc_c1 flushes got=%b exp=1100", {hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush}); end
    checks++; if (hif.D_ena !== 1'b1) begin failures++; $display("FAIL exc_sb_cleared D_ena got=%b exp=1", hif.D_ena); end
    cyc(); settle();
    checks++; if ({hif.F_flush, hif.D_flush} !== 2'b11) begin failures++; $display("FAIL exc_c2 F/D_flush got=%b exp=11", {hif.F_flush, hif.D_flush}); end
    cyc(); settle();
    checks++; if ({hif.F_flush, hif.D_flush, hif.D_issue_mask} !== 4'b0001) begin failures++; $display("FAIL exc_done flush,mask got=%b exp=0001", {hif.F_flush, hif.D_flush, hif.D_issue_mask}); end
    checks++; if (hif.lu_stall_cnt !== 3'd3) begin failures++; $display("FAIL exc_cnt got=%0d exp=3", hif.lu_stall_cnt); end
    // restart of the flush window by a second exception
    idle(1); hif.M_except = 1; hif.E_alu_stall = 1; settle();
    checks++; if ({hif.W_ena, hif.E_ena, hif.F_flush} !== 3'b100) begin failures++; $display("FAIL exc_wena W,E,F_flush got=%b exp=100", {hif.W_ena, hif.E_ena, hif.F_flush}); end
    cyc(); clear_in(); settle();
    cyc(); hif.M_except = 1; settle();
    checks++; if ({hif.F_flush, hif.M_flush} !== 2'b11) begin failures++; $display("FAIL exc_re F,M_flush got=%b exp=11", {hif.F_flush, hif.M_flush}); end
    cyc(); hif.M_except = 0; settle();
    cyc(); settle();
    checks++; if (hif.F_flush !== 1'b1) begin failures++; $display("FAIL exc_restart_held F_flush got=%b exp=1", hif.F_flush); end
    cyc(); settle();
    checks++; if (hif.F_flush !== 1'b0) begin failures++; $display("FAIL exc_restart_end F_flush got=%b exp=0", hif.F_flush); end
    cyc(); hif.E_branch_taken = 1; set_lane(0, 0, 0, 5'd0, 5'd1, 5'd2); settle();
    checks++; if ({hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.D_issue_mask} !== 6'b011000) begin failures++; $display("FAIL branch flushes,mask got=%b exp=011000", {hif.F_flush, hif.D_flush, hif.E_flush, hif.M_flush, hif.D_issue_mask}); end
  endtask

  task automatic test_stall_hold();
    idle(3);
    set_lane(0, 1, 1, 5'd5, 5'd1, 5'd2);
    cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd5, 5'd0); hif.i_stall = 1; settle();
    checks++; if ({hif.F_ena, hif.D_ena, hif.E_ena, hif.M_ena, hif.W_ena, hif.D_issue_mask} !== 7'b0000000) begin failures++; $display("FAIL hold_enables got=%b exp=0000000", {hif.F_ena, hif.D_ena, hif.E_ena, hif.M_ena, hif.W_ena, hif.D_issue_mask}); end
    repeat (2) cyc();
    settle();
    checks++; if (hif.lu_stall_cnt !== 3'd3) begin failures++; $display("FAIL hold_cnt_frozen got=%0d exp=3", hif.lu_stall_cnt); end
    cyc(); hif.i_stall = 0; settle();
    checks++; if (hif.D_ena !== 1'b0) begin failures++; $display("FAIL hold_sb_kept D_ena got=%b exp=0", hif.D_ena); end
    cyc(); settle();
    checks++; if (hif.D_ena !== 1'b0) begin failures++; $display("FAIL hold_sb_age D_ena got=%b exp=0", hif.D_ena); end
    cyc(); settle();
    checks++; if ({hif.D_ena, hif.D_issue_mask} !== 3'b101) begin failures++; $display("FAIL hold_release D,mask got=%b exp=101", {hif.D_ena, hif.D_issue_mask}); end
    checks++; if (hif.lu_stall_cnt !== 3'd5) begin failures++; $display("FAIL hold_cnt got=%0d exp=5", hif.lu_stall_cnt); end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 2; r++) begin
      idle(3);
      set_lane(0, 1, 1, 5'd5, 5'd1, 5'd2);
      cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd5, 5'd0);
      repeat (2) cyc();
      settle();
      checks++; if ({hif.D_ena, hif.lu_stall_cnt} !== 4'b1111) begin failures++; $display("FAIL sat%0d D_ena,cnt got=%b exp=1111", r, {hif.D_ena, hif.lu_stall_cnt}); end
    end
  endtask

  task automatic test_reset_mid_hold();
    idle(3);
    set_lane(0, 1, 1, 5'd5, 5'd1, 5'd2);
    cyc(); clear_in(); set_lane(0, 0, 0, 5'd0, 5'd5, 5'd0); hif.i_stall = 1;
    cyc(); #1;
    resetn = 1'b0;
    #1;
    checks++; if ({hif.D_ena, hif.lu_stall_cnt} !== 4'b0000) begin failures++; $display("FAIL rst_hold D_ena,cnt got=%b exp=0000", {hif.D_ena, hif.lu_stall_cnt}); end
    hif.i_stall = 0;
    #1;
    checks++; if ({hif.D_ena, hif.F_ena, hif.D_issue_mask} !== 4'b1101) begin failures++; $display("FAIL rst_dropped D,F,mask got=%b exp=1101", {hif.D_ena, hif.F_ena, hif.D_issue_mask}); end
    cyc(); resetn = 1'b1; settle();
    checks++; if ({hif.D_ena, hif.D_issue_mask, hif.lu_stall_cnt} !== 6'b101000) begin failures++; $display("FAIL rst_after D,mask,cnt got=%b exp=101000", {hif.D_ena, hif.D_issue_mask, hif.lu_stall_cnt}); end
    // reset while the flush sequencer is active
    idle(1); hif.M_except = 1;
    cyc(); hif.M_except = 0; settle();
    checks++; if (hif.F_flush !== 1'b1) begin failures++; $display("FAIL rst_exc_pre F_flush got=%b exp=1", hif.F_flush); end
    resetn = 1'b0;
    #1;
    checks++; if ({hif.F_flush, hif.D_flush} !== 2'b00) begin failures++; $display("FAIL rst_exc F/D_flush got=%b exp=00", {hif.F_flush, hif.D_flush}); end
    cyc(); resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_in();
    test_reset();
    test_load_use();
    test_lane1_shadow();
    test_intra_raw();
    test_zero();
    test_except();
    test_stall_hold();
    test_saturate();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
